// File: rtl/iflow_decode_bus.sv
// iflow_decode_bus
//   Instruction-execution control slice: phase generator, three-state decoder
//   FSM (IDLE -> EXEC -> COMMIT) and a registered source->destination crossbar.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   instruction_in/_ready      opcode from fetcher and its valid strobe
//   addr_in                    effective address from fetcher
//   *_in                       bus sources (PC, SP, ADD, X, Y, STAT, MEM, IMM,
//                              FETCH, DECODE, ALU)
//   fetch_selector             fetcher-owned source select for fetch_out
//   phi1, phi2                 non-overlapping phase enables
//   we                         write enables {DOUT,STAT,Y,X,ADD,SP,PC}
//   instruction_done           one-cycle pulse in the commit cycle
//   opp, mem_addr              latched opcode and effective address
//   *_out                      registered bus destinations
module iflow_decode_bus #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int WE_WIDTH   = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_WIDTH-1:0]  instruction_in,
    input  logic                  instruction_ready,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [REG_WIDTH-1:0]  pc_in,
    input  logic [REG_WIDTH-1:0]  sp_in,
    input  logic [REG_WIDTH-1:0]  add_in,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    input  logic [REG_WIDTH-1:0]  stat_in,
    input  logic [REG_WIDTH-1:0]  mem_in,
    input  logic [REG_WIDTH-1:0]  imm_in,
    input  logic [REG_WIDTH-1:0]  fetch_in,
    input  logic [REG_WIDTH-1:0]  decode_in,
    input  logic [REG_WIDTH-1:0]  alu_in,
    input  logic [3:0]            fetch_selector,
    output logic                  phi1,
    output logic                  phi2,
    output logic [WE_WIDTH-1:0]   we,
    output logic                  instruction_done,
    output logic [REG_WIDTH-1:0]  opp,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  pc_out,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic [REG_WIDTH-1:0]  add_out,
    output logic [REG_WIDTH-1:0]  x_out,
    output logic [REG_WIDTH-1:0]  y_out,
    output logic [REG_WIDTH-1:0]  stat_out,
    output logic [REG_WIDTH-1:0]  mem_out,
    output logic [REG_WIDTH-1:0]  fetch_out,
    output logic [REG_WIDTH-1:0]  decode_out,
    output logic [REG_WIDTH-1:0]  alu0_out,
    output logic [REG_WIDTH-1:0]  alu1_out
);

    localparam logic [3:0] SEL_Y    = 4'd4;
    localparam logic [3:0] SEL_MEM  = 4'd6;
    localparam logic [3:0] SEL_IMM  = 4'd7;
    localparam logic [3:0] SEL_NONE = 4'd15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EXEC   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int WE_ADD  = 2;
    localparam int WE_Y    = 4;
    localparam int WE_DOUT = 6;

    logic                phase;
    logic [1:0]          state;
    logic [3:0]          add_sel, y_sel, mem_sel;
    logic [WE_WIDTH-1:0] we_dec;

    // Source crossbar: codes 11..15 select nothing and yield zero.
    function automatic logic [REG_WIDTH-1:0] route(input logic [3:0] sel);
        case (sel)
            4'd0:    route = pc_in;
            4'd1:    route = sp_in;
            4'd2:    route = add_in;
            4'd3:    route = x_in;
            4'd4:    route = y_in;
            4'd5:    route = stat_in;
            4'd6:    route = mem_in;
            4'd7:    route = imm_in;
            4'd8:    route = fetch_in;
            4'd9:    route = decode_in;
            4'd10:   route = alu_in;
            default: route = '0;
        endcase
    endfunction

    // Per-opcode selectors and write enables. Selectors are live in both EXEC
    // and COMMIT so the routed value is stable while the write is committed;
    // the write-enable pattern is only registered out on the EXEC->COMMIT edge.
    always_comb begin
        add_sel = SEL_NONE;
        y_sel   = SEL_NONE;
        mem_sel = SEL_NONE;
        we_dec  = '0;
        case (opp)
            8'hA5, 8'hAD: begin add_sel = SEL_MEM; we_dec[WE_ADD]  = 1'b1; end
            8'hA0:        begin y_sel   = SEL_IMM; we_dec[WE_Y]    = 1'b1; end
            8'h84:        begin mem_sel = SEL_Y;   we_dec[WE_DOUT] = 1'b1; end
            default:      ;
        endcase
        if (state == ST_IDLE) begin
            add_sel = SEL_NONE;
            y_sel   = SEL_NONE;
            mem_sel = SEL_NONE;
        end
    end

    assign phi1 = ~phase;
    assign phi2 = phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase            <= 1'b0;
            state            <= ST_IDLE;
            we               <= '0;
            instruction_done <= 1'b0;
            opp              <= '0;
            mem_addr         <= '0;
            pc_out           <= '0;
            sp_out           <= '0;
            add_out          <= '0;
            x_out            <= '0;
            y_out            <= '0;
            stat_out         <= '0;
            mem_out          <= '0;
            fetch_out        <= '0;
            decode_out       <= '0;
            alu0_out         <= '0;
            alu1_out         <= '0;
        end else begin
            phase <= ~phase;

            case (state)
                ST_IDLE: begin
                    we               <= '0;
                    instruction_done <= 1'b0;
                    if (instruction_ready) begin
                        opp      <= instruction_in;
                        mem_addr <= addr_in;
                        state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    we               <= we_dec;
                    instruction_done <= 1'b1;
                    state            <= ST_COMMIT;
                end
                default: begin
                    we               <= '0;
                    instruction_done <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase

            // Destinations without a decoder-driven selector always load NONE.
            pc_out     <= route(SEL_NONE);
            sp_out     <= route(SEL_NONE);
            add_out    <= route(add_sel);
            x_out      <= route(SEL_NONE);
            y_out      <= route(y_sel);
            stat_out   <= route(SEL_NONE);
            mem_out    <= route(mem_sel);
            fetch_out  <= route(fetch_selector);
            decode_out <= route(SEL_NONE);
            alu0_out   <= route(SEL_NONE);
            alu1_out   <= route(SEL_NONE);
        end
    end

endmodule

// File: tb/tb_iflow_decode_bus.sv
module tb_iflow_decode_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  instruction_in;
    logic        instruction_ready;
    logic [15:0] addr_in;
    logic [7:0]  src [11];
    logic [3:0]  fetch_selector;
    logic        phi1, phi2, instruction_done;
    logic [6:0]  we;
    logic [7:0]  opp;
    logic [15:0] mem_addr;
    logic [7:0]  pc_out, sp_out, add_out, x_out, y_out, stat_out, mem_out;
    logic [7:0]  fetch_out, decode_out, alu0_out, alu1_out;

    always #5 clk = ~clk;

    iflow_decode_bus dut (
        .clk(clk), .reset(reset),
        .instruction_in(instruction_in), .instruction_ready(instruction_ready),
        .addr_in(addr_in),
        .pc_in(src[0]), .sp_in(src[1]), .add_in(src[2]), .x_in(src[3]),
        .y_in(src[4]), .stat_in(src[5]), .mem_in(src[6]), .imm_in(src[7]),
        .fetch_in(src[8]), .decode_in(src[9]), .alu_in(src[10]),
        .fetch_selector(fetch_selector),
        .phi1(phi1), .phi2(phi2), .we(we), .instruction_done(instruction_done),
        .opp(opp), .mem_addr(mem_addr),
        .pc_out(pc_out), .sp_out(sp_out), .add_out(add_out), .x_out(x_out),
        .y_out(y_out), .stat_out(stat_out), .mem_out(mem_out),
        .fetch_out(fetch_out), .decode_out(decode_out),
        .alu0_out(alu0_out), .alu1_out(alu1_out)
    );

    typedef struct {
        int          cyc;
        logic [6:0]  we;
        logic [7:0]  opp;
        logic [15:0] addr;
        logic [7:0]  add, y, mem;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: what a committed instruction writes, straight from the opcode table.
    function automatic exp_t model(input logic [7:0] op, input logic [15:0] a, input int c);
        exp_t e;
        e.cyc = c; e.we = '0; e.opp = op; e.addr = a;
        e.add = 8'h00; e.y = 8'h00; e.mem = 8'h00;
        case (op)
            8'hA5, 8'hAD: begin e.we = 7'b0000100; e.add = src[6]; end
            8'hA0:        begin e.we = 7'b0010000; e.y   = src[7]; end
            8'h84:        begin e.we = 7'b1000000; e.mem = src[4]; end
            default:      ;
        endcase
        return e;
    endfunction

    // Fetcher owns fetch_selector; it wanders independently of the decoder.
    initial begin
        fetch_selector = 4'd0;
        forever begin
            @(posedge clk); #1;
            fetch_selector = 4'($urandom_range(0, 15));
        end
    end

    // Monitor state from the previous sample
    logic       prev_rst, prev_phi2;
    logic [3:0] prev_sel;
    logic [7:0] prev_src [11];

    initial begin
        exp_t e;
        logic [7:0] fexp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("phase_excl", 32'(phi1 ^ phi2), 1);
                chk("phase_seq", 32'(phi1), prev_rst ? 1 : 32'(prev_phi2));
                fexp = (prev_rst || prev_sel > 4'd10) ? 8'h00 : prev_src[prev_sel];
                chk("fetch_out", 32'(fetch_out), 32'(fexp));
                chk("unused_dest", 32'(|{pc_out, sp_out, x_out, stat_out,
                                         decode_out, alu0_out, alu1_out}), 0);
                if (instruction_done) begin
                    if (q.size() == 0) begin
                        chk("spurious_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("we", 32'(we), 32'(e.we));
                        chk("opp", 32'(opp), 32'(e.opp));
                        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
                        chk("add_out", 32'(add_out), 32'(e.add));
                        chk("y_out", 32'(y_out), 32'(e.y));
                        chk("mem_out", 32'(mem_out), 32'(e.mem));
                    end
                end else begin
                    chk("we_idle", 32'(we), 0);
                    if (q.size() != 0 && q[0].cyc < cyc) begin
                        e = q.pop_front();
                        chk("missed_done", 32'(cyc), 32'(e.cyc));
                    end
                end
            end
            prev_rst  = reset;
            prev_phi2 = phi2;
            prev_sel  = fetch_selector;
            prev_src  = src;
        end
    end

    task automatic rand_src();
        for (int i = 0; i < 11; i++) src[i] = 8'($urandom);
    endtask

    // Issue one instruction in the current cycle. junk drives ready (with
    // opcode 0xAD) during EXEC/COMMIT, which must be ignored; rst_exec pulls
    // reset during EXEC so nothing may commit.
    task automatic issue(input logic [7:0] op, input logic [15:0] a,
                         input bit junk, input bit rst_exec);
        instruction_in    = op;
        addr_in           = a;
        instruction_ready = 1'b1;
        if (!rst_exec) q.push_back(model(op, a, cyc + 2));
        @(posedge clk); #1;
        instruction_in    = 8'hAD;
        addr_in           = 16'($urandom);
        instruction_ready = junk;
        if (rst_exec) reset = 1'b1;
        @(posedge clk); #1;
        reset             = 1'b0;
        instruction_ready = rst_exec ? 1'b0 : junk;
        @(posedge clk); #1;
        instruction_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ops [5];
        logic [7:0] op;
        ops[0] = 8'hEA; ops[1] = 8'hA5; ops[2] = 8'hAD; ops[3] = 8'hA0; ops[4] = 8'h84;
        reset = 1'b1; instruction_ready = 1'b0; instruction_in = 8'h00; addr_in = 16'h0;
        rand_src();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_phi1", 32'(phi1), 1);
        chk("rst_phi2", 32'(phi2), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_done", 32'(instruction_done), 0);
        chk("rst_opp", 32'(opp), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_bus", 32'(|{pc_out, sp_out, add_out, x_out, y_out, stat_out, mem_out,
                            fetch_out, decode_out, alu0_out, alu1_out}), 0);
        prev_rst = 1'b1; prev_phi2 = phi2; prev_sel = fetch_selector; prev_src = src;
        #1 mon_en = 1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        issue(8'hEA, 16'h1234, 0, 0);
        src[6] = 8'h5C;
        issue(8'hA5, 16'h0010, 0, 0);
        src[7] = 8'h33;
        issue(8'hA0, 16'h0020, 0, 0);
        src[4] = 8'h33;
        issue(8'h84, 16'h0030, 0, 0);
        rand_src();
        issue(8'hA0, 16'h0040, 1, 0);
        issue(8'hA5, 16'h0050, 0, 1);
        issue(8'h84, 16'h0060, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            repeat ($urandom_range(0, 2)) begin
                rand_src();
                @(posedge clk); #1;
            end
            rand_src();
            op = ($urandom_range(0, 5) == 5) ? 8'($urandom) : ops[$urandom_range(0, 4)];
            issue(op, 16'($urandom), bit'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
        end

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/iflow_decode_bus.md
Name: iflow_decode_bus

Overview:
Instruction-execution control slice of the CPU core, merging the phase generator, the decoder FSM and the registered data-bus crossbar into one block. It accepts a fetched opcode plus its effective address and operand, then routes sources onto the register, memory and ALU input ports. It also issues the write enables that commit each instruction. It sits between the fetcher, which supplies the opcode, imm and address, and the register file and memory, which consume the routed data and write enables.

Parameters:
REG_WIDTH, 8, data/register width
ADDR_WIDTH, 16, address width
WE_WIDTH, 7, write-enable vector width

Ports:
clk  input  1  single system clock; all state on rising edge
reset  input  1  synchronous, active-high reset
instruction_in  input  8  opcode from fetcher
instruction_ready  input  1  opcode/addr/imm valid this cycle
addr_in  input  16  effective address from fetcher
pc_in, sp_in, add_in, x_in, y_in, stat_in, mem_in, imm_in, fetch_in, decode_in, alu_in  input  8 each  bus sources
fetch_selector  input  4  source select for fetch_out (owned by fetcher)
phi1, phi2  output  1 each  non-overlapping phase enables
we  output  7  write enables: bit0 PC, 1 SP, 2 ADD, 3 X, 4 Y, 5 STAT, 6 DOUT (memory)
instruction_done  output  1  one-cycle pulse at commit
opp  output  8  latched opcode
mem_addr  output  16  latched effective address
pc_out, sp_out, add_out, x_out, y_out, stat_out, mem_out, fetch_out, decode_out, alu0_out, alu1_out  output  8 each  routed destinations

Behaviour:
- Reset behaviour: phase=0, giving phi1=1 and phi2=0. State=IDLE. we=0, instruction_done=0, opp=8'h00, mem_addr=0. All bus outputs are 8'h00.
- Phase generator: phase toggles every clk; phi1=~phase, phi2=phase; exactly one is high at any time.
- Selector codes (4-bit): 0 PC, 1 SP, 2 ADD, 3 X, 4 Y, 5 STAT, 6 MEM, 7 IMM, 8 FETCH, 9 DECODE, 10 ALU, 11-15 NONE.
- Bus: each destination is registered; on each clk it loads the selected source. NONE loads 8'h00. Latency is 1 clk from selector to output. One source may feed several destinations in the same cycle.
- Decoder FSM states: IDLE, EXEC, COMMIT.
- IDLE: all internal selectors are NONE and we=0. If instruction_ready=1, latch instruction_in into opp and addr_in into mem_addr, then go to EXEC. Otherwise stay in IDLE.
- EXEC (1 cycle): drive the per-opcode selectors; we=0. Go to COMMIT.
- COMMIT (1 cycle): hold the selectors, assert the per-opcode we bit(s), and assert instruction_done=1. Go to IDLE.
- Total latency: ready at cycle N -> we/instruction_done at cycle N+2; a new instruction is accepted in cycle N+3 at the earliest.
- instruction_ready is ignored while in EXEC or COMMIT.
- Opcode table:
  - 0xEA NOP: no selectors; we=0; done pulses.
  - 0xA5 LDA zpg and 0xAD LDA abs: add_selector=MEM; we[2].
  - 0xA0 LDY imm: y_selector=IMM; we[4].
  - 0x84 STY zpg: mem_selector=Y; we[6].
  - Any other opcode is treated as NOP.
- STAT flags are not updated by any opcode in this block.
- fetch_out always follows fetch_selector, independent of the FSM state.
- Reset asserted in any state forces IDLE on the next edge and clears we and done. A partial instruction is dropped with no write.

Test Plan:
- Reset held 2 clks -> phi1=1, phi2=0, we=0, all bus outputs 00. Release -> phi1/phi2 alternate each clk.
- 0xEA with ready=1 -> done pulses at N+2, we=0 throughout, opp=EA.
- 0xA5, addr_in=0x0010, mem_in=0x5C -> mem_addr=0x0010; add_out=5C and we=0000100b with done at N+2.
- 0xA0, imm_in=0x33 -> y_out=33, we[4]=1 at N+2. Then 0x84 with y_in=0x33 -> mem_out=33, we[6]=1.
- ready asserted during EXEC with opcode 0xAD -> ignored; only the first instruction commits.
- Reset in EXEC after 0xA5 -> next cycle IDLE; no we pulse and no done.
